// File: rtl/nes_joypad_pkg.sv
// Shared constants and key-decode helpers for the NES joypad controller.
// Holds button bit indices, USB HID keycode maps and the $4016/$4017 open-bus value.
package nes_joypad_pkg;

    typedef logic [7:0] btn_t;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam logic [7:0] KEY_ROLLOVER = 8'h01;
    localparam logic [7:0] KEY_TURBO_A  = 8'h0C;
    localparam logic [7:0] KEY_TURBO_B  = 8'h0B;
    localparam logic [7:0] OPEN_BUS     = 8'h40;

    // Keymaps packed Right..A, so button b lives at [b*8 +: 8].
    localparam logic [63:0] PAD0_KEYMAP = {8'h07, 8'h04, 8'h16, 8'h1A,
                                           8'h28, 8'h2B, 8'h0D, 8'h0E};
    localparam logic [63:0] PAD1_KEYMAP = {8'h4F, 8'h50, 8'h51, 8'h52,
                                           8'h34, 8'h35, 8'h36, 8'h37};

    function automatic logic key_held(input logic [23:0] keys, input logic [7:0] code);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (keys[k*8 +: 8] == code) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic btn_t decode_keys(input logic [23:0] keys, input logic [63:0] keymap);
        btn_t btn;
        btn = '0;
        for (int b = 0; b < 8; b++) begin
            btn[b] = key_held(keys, keymap[b*8 +: 8]);
        end
        return btn;
    endfunction

    function automatic btn_t cancel_opposing(input btn_t btn_in);
        btn_t btn;
        btn = btn_in;
        if (btn[BTN_UP] && btn[BTN_DOWN]) begin
            btn[BTN_UP]   = 1'b0;
            btn[BTN_DOWN] = 1'b0;
        end
        if (btn[BTN_LEFT] && btn[BTN_RIGHT]) begin
            btn[BTN_LEFT]  = 1'b0;
            btn[BTN_RIGHT] = 1'b0;
        end
        return btn;
    endfunction

endpackage

// File: rtl/nes_joypad_port.sv
// One NES controller serial port: parallel reload while strobe is high,
// otherwise shift right on each read with ones filling from the top.
module nes_joypad_port
    import nes_joypad_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       strobe,
    input  logic       rd,
    input  logic [7:0] live_btn,
    output logic       data_bit
);

    btn_t shift_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
        end else if (strobe) begin
            shift_reg <= live_btn;
        end else if (rd) begin
            shift_reg <= {1'b1, shift_reg[7:1]};
        end
    end

    assign data_bit = shift_reg[0];

endmodule

// File: rtl/nes_joypad_ctrl.sv
// USB-keyboard-to-NES joypad bridge exposing $4016/$4017 to the CPU.
// Optional turbo A/B on pad 0 is enabled by defining JOYPAD_TURBO_EN.
module nes_joypad_ctrl
    import nes_joypad_pkg::*;
#(
    parameter int TURBO_FRAMES = 2
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic [7:0] keycode_export,
    input  logic [7:0] keycode2_export,
    input  logic [7:0] keycode3_export,
    input  logic       frame_tick,
    input  logic       cpu_wr,
    input  logic       cpu_rd,
    input  logic       cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic [7:0] cpu_rdata,
    output logic [7:0] pad0_state
);

    logic [23:0]      keys;
    logic             rollover;
    logic [1:0][7:0]  btn_next;
    logic [1:0][7:0]  live_btn_reg;
    logic [1:0]       serial_bit;
    logic             strobe_reg;
    logic [7:0]       rdata_reg;
    logic             unused_inputs;

    assign keys     = {keycode3_export, keycode2_export, keycode_export};
    assign rollover = key_held(keys, KEY_ROLLOVER);

`ifdef JOYPAD_TURBO_EN
    logic [7:0] turbo_cnt_reg;
    logic       turbo_phase_reg;
    logic       turbo_a;
    logic       turbo_b;

    assign turbo_a = key_held(keys, KEY_TURBO_A);
    assign turbo_b = key_held(keys, KEY_TURBO_B);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            turbo_cnt_reg   <= '0;
            turbo_phase_reg <= 1'b0;
        end else if (frame_tick) begin
            if (turbo_cnt_reg == 8'(TURBO_FRAMES - 1)) begin
                turbo_cnt_reg   <= '0;
                turbo_phase_reg <= ~turbo_phase_reg;
            end else begin
                turbo_cnt_reg <= turbo_cnt_reg + 8'd1;
            end
        end
    end

    assign unused_inputs = ^cpu_wdata[7:1];
`else
    assign unused_inputs = ^{cpu_wdata[7:1], frame_tick, 8'(TURBO_FRAMES)};
`endif

    always_comb begin
        btn_next[0] = cancel_opposing(decode_keys(keys, PAD0_KEYMAP));
        btn_next[1] = cancel_opposing(decode_keys(keys, PAD1_KEYMAP));
`ifdef JOYPAD_TURBO_EN
        btn_next[0][BTN_A] = btn_next[0][BTN_A] | (turbo_a & turbo_phase_reg);
        btn_next[0][BTN_B] = btn_next[0][BTN_B] | (turbo_b & turbo_phase_reg);
`endif
        // A rollover report means the key list is garbage: drop everything.
        if (rollover) begin
            btn_next = '0;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            live_btn_reg <= '0;
            strobe_reg   <= 1'b0;
            rdata_reg    <= '0;
        end else begin
            live_btn_reg <= btn_next;
            if (cpu_wr && !cpu_addr) begin
                strobe_reg <= cpu_wdata[0];
            end
            // serial_bit is the pre-shift value, so a same-cycle write cannot disturb it.
            if (cpu_rd) begin
                rdata_reg <= OPEN_BUS | {7'b0, serial_bit[cpu_addr]};
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            nes_joypad_port u_port (
                .clk      (clk_clk),
                .rst_n    (reset_reset_n),
                .strobe   (strobe_reg),
                .rd       (cpu_rd && (cpu_addr == 1'(gi))),
                .live_btn (live_btn_reg[gi]),
                .data_bit (serial_bit[gi])
            );
        end
    endgenerate

    assign cpu_rdata  = rdata_reg;
    assign pad0_state = live_btn_reg[0];

endmodule

// File: tb/tb_nes_joypad_ctrl.sv
// Self-checking bench for nes_joypad_ctrl: a read-index model of the pads
// checked every cycle, plus directed reads with hand-computed values.
module tb_nes_joypad_ctrl;

    localparam int TF = 2;

    logic       clk = 1'b0;
    logic       reset_reset_n = 1'b0;
    logic [7:0] keycode_export = '0;
    logic [7:0] keycode2_export = '0;
    logic [7:0] keycode3_export = '0;
    logic       frame_tick = 1'b0;
    logic       cpu_wr = 1'b0;
    logic       cpu_rd = 1'b0;
    logic       cpu_addr = 1'b0;
    logic [7:0] cpu_wdata = '0;
    logic [7:0] cpu_rdata;
    logic [7:0] pad0_state;

    int n_checks = 0;
    int n_fail   = 0;

    nes_joypad_ctrl #(.TURBO_FRAMES(TF)) dut (
        .clk_clk         (clk),
        .reset_reset_n   (reset_reset_n),
        .keycode_export  (keycode_export),
        .keycode2_export (keycode2_export),
        .keycode3_export (keycode3_export),
        .frame_tick      (frame_tick),
        .cpu_wr          (cpu_wr),
        .cpu_rd          (cpu_rd),
        .cpu_addr        (cpu_addr),
        .cpu_wdata       (cpu_wdata),
        .cpu_rdata       (cpu_rdata),
        .pad0_state      (pad0_state)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [7:0] keymap [2][8] = '{'{8'h0E, 8'h0D, 8'h2B, 8'h28, 8'h1A, 8'h16, 8'h04, 8'h07},
                                  '{8'h37, 8'h36, 8'h35, 8'h34, 8'h52, 8'h51, 8'h50, 8'h4F}};

    function automatic logic [7:0] model_pad(input int pad, input logic [7:0] a, input logic [7:0] b,
                                             input logic [7:0] c, input logic phase);
        logic [7:0] held [3];
        logic [7:0] btn;
        held = '{a, b, c};
        btn = '0;
        for (int k = 0; k < 3; k++) begin
            if (held[k] == 8'h01) return 8'h00;
            for (int i = 0; i < 8; i++) if (held[k] == keymap[pad][i]) btn[i] = 1'b1;
`ifdef JOYPAD_TURBO_EN
            if (pad == 0 && held[k] == 8'h0C && phase) btn[0] = 1'b1;
            if (pad == 0 && held[k] == 8'h0B && phase) btn[1] = 1'b1;
`endif
        end
        if (btn[4] && btn[5]) btn[5:4] = 2'b00;
        if (btn[6] && btn[7]) btn[7:6] = 2'b00;
        return btn;
    endfunction

    logic [7:0] m_live [2];
    logic [7:0] m_snap [2];
    int         m_idx  [2];
    logic       m_strobe;
    logic [7:0] m_rdata;
    int         m_ticks;

    always @(posedge clk) begin : model
        int   p;
        logic bitv;
        logic phase;
        if (!reset_reset_n) begin
            m_live = '{8'h00, 8'h00};
            m_snap = '{8'h00, 8'h00};
            m_idx = '{0, 0};
            m_strobe = 1'b0;
            m_rdata = 8'h00;
            m_ticks = 0;
        end else begin
            if (cpu_rd) begin
                p = int'(cpu_addr);
                if (m_strobe) bitv = m_live[p][0];
                else if (m_idx[p] < 8) bitv = m_snap[p][m_idx[p]];
                else bitv = 1'b1;
                m_rdata = 8'h40 | {7'b0, bitv};
                if (!m_strobe && m_idx[p] < 8) m_idx[p] = m_idx[p] + 1;
            end
            if (m_strobe) begin
                m_snap = m_live;
                m_idx = '{0, 0};
            end
            if (cpu_wr && !cpu_addr) m_strobe = cpu_wdata[0];
            phase = ((m_ticks / TF) % 2) == 1;
            m_live[0] = model_pad(0, keycode_export, keycode2_export, keycode3_export, phase);
            m_live[1] = model_pad(1, keycode_export, keycode2_export, keycode3_export, 1'b0);
            if (frame_tick) m_ticks = m_ticks + 1;
        end
    end

    always @(negedge clk) begin
        logic [7:0] exp_rd;
        logic [7:0] exp_pad;
        exp_rd  = reset_reset_n ? m_rdata : 8'h00;
        exp_pad = reset_reset_n ? m_live[0] : 8'h00;
        n_checks++;
        if (cpu_rdata !== exp_rd) begin
            n_fail++;
            $display("FAIL model_rdata t=%0t got=%02h exp=%02h", $time, cpu_rdata, exp_rd);
        end
        n_checks++;
        if (pad0_state !== exp_pad) begin
            n_fail++;
            $display("FAIL model_pad0 t=%0t got=%02h exp=%02h", $time, pad0_state, exp_pad);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%02h exp=%02h", nm, act, exp);
        end else begin
            $display("ok   %s = %02h", nm, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_keys(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        keycode_export = a;
        keycode2_export = b;
        keycode3_export = c;
        step();
        step();
    endtask

    task automatic do_wr(input logic a, input logic [7:0] d);
        cpu_wr = 1'b1;
        cpu_addr = a;
        cpu_wdata = d;
        step();
        cpu_wr = 1'b0;
        step();
    endtask

    task automatic do_rd(input logic a, input logic [7:0] exp, input string nm);
        cpu_rd = 1'b1;
        cpu_addr = a;
        step();
        cpu_rd = 1'b0;
        @(negedge clk);
        chk(nm, cpu_rdata, exp);
        step();
    endtask

    task automatic chk_pad(input logic [7:0] exp, input string nm);
        @(negedge clk);
        chk(nm, pad0_state, exp);
        step();
    endtask

    logic [7:0] seq_a [9] = '{8'h41, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h41};
    logic [7:0] seq_p1 [8] = '{8'h40, 8'h40, 8'h40, 8'h40, 8'h41, 8'h40, 8'h40, 8'h41};

    initial begin
        step();
        step();
        @(negedge clk);
        chk("reset_rdata", cpu_rdata, 8'h00);
        chk("reset_pad0", pad0_state, 8'h00);
        step();
        reset_reset_n = 1'b1;
        step();

        // Pad 0 A held: full 8-bit readout then the ones tail
        set_keys(8'h0E, 8'h00, 8'h00);
        chk_pad(8'h01, "pad0_a");
        do_wr(1'b0, 8'h01);
        do_wr(1'b0, 8'h00);
        for (int i = 0; i < 9; i++) do_rd(1'b0, seq_a[i], $sformatf("a_read%0d", i));

        set_keys(8'h1A, 8'h16, 8'h07);
        chk_pad(8'h80, "updown_cancel");
        set_keys(8'h04, 8'h07, 8'h0E);
        chk_pad(8'h01, "leftright_cancel");
        set_keys(8'h28, 8'h00, 8'h00);
        chk_pad(8'h08, "start");
        set_keys(8'h28, 8'h01, 8'h00);
        chk_pad(8'h00, "rollover");

        // Strobe held: $4017 keeps returning live A
        set_keys(8'h00, 8'h00, 8'h37);
        do_wr(1'b0, 8'h01);
        for (int i = 0; i < 3; i++) do_rd(1'b1, 8'h41, $sformatf("strobe_p1_%0d", i));
        do_rd(1'b0, 8'h40, "strobe_p0");
        do_wr(1'b0, 8'h00);
        do_rd(1'b1, 8'h41, "p1_after_strobe0");
        do_rd(1'b1, 8'h40, "p1_after_strobe1");

        // Pad 1 Up+Right = 0x90 serial readout
        set_keys(8'h4F, 8'h52, 8'h00);
        do_wr(1'b0, 8'h01);
        do_wr(1'b0, 8'h00);
        for (int i = 0; i < 8; i++) do_rd(1'b1, seq_p1[i], $sformatf("p1_read%0d", i));

        // Write to $4017 does not touch the strobe
        set_keys(8'h0D, 8'h00, 8'h00);
        do_wr(1'b0, 8'h01);
        do_wr(1'b0, 8'h00);
        do_rd(1'b0, 8'h40, "b_read0");
        do_wr(1'b1, 8'h01);
        do_rd(1'b0, 8'h41, "b_read1_after_4017wr");
        do_rd(1'b0, 8'h40, "b_read2");

        // Same-cycle read and strobe write: read gets the pre-write bit
        set_keys(8'h0E, 8'h00, 8'h00);
        do_wr(1'b0, 8'h01);
        do_wr(1'b0, 8'h00);
        do_rd(1'b0, 8'h41, "rw_read0");
        cpu_rd = 1'b1;
        cpu_wr = 1'b1;
        cpu_addr = 1'b0;
        cpu_wdata = 8'h01;
        step();
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        @(negedge clk);
        chk("rw_same_cycle", cpu_rdata, 8'h40);
        step();
        do_rd(1'b0, 8'h41, "rw_after_strobe");
        do_wr(1'b0, 8'h00);

        // Reset in the middle of a read sequence
        do_wr(1'b0, 8'h01);
        do_wr(1'b0, 8'h00);
        do_rd(1'b0, 8'h41, "mid_read0");
        do_rd(1'b0, 8'h40, "mid_read1");
        do_rd(1'b0, 8'h40, "mid_read2");
        reset_reset_n = 1'b0;
        @(negedge clk);
        chk("midreset_rdata", cpu_rdata, 8'h00);
        chk("midreset_pad0", pad0_state, 8'h00);
        step();
        step();
        reset_reset_n = 1'b1;
        step();
        step();
        do_rd(1'b0, 8'h40, "after_reset_read");

`ifdef JOYPAD_TURBO_EN
        set_keys(8'h0C, 8'h00, 8'h00);
        chk_pad(8'h00, "turbo_start");
        for (int t = 1; t <= 8; t++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            step();
            step();
            chk_pad(((t / 2) % 2) == 1 ? 8'h01 : 8'h00, $sformatf("turbo_tick%0d", t));
        end
`else
        set_keys(8'h0C, 8'h0B, 8'h00);
        chk_pad(8'h00, "turbo_disabled");
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        step();
        chk_pad(8'h00, "turbo_disabled_tick");
`endif

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
